// File: rtl/synth_test_sequencer_if.sv
// Method-port bundle between the test sequencer and one DUT method.
// master = sequencer side, slave = DUT method side.
interface synth_test_sequencer_if;
   logic [31:0] test_idx;
   logic        test_req;
   logic        test_busy;
   logic        test_return;

   modport master (
      output test_idx,
      output test_req,
      input  test_busy,
      input  test_return
   );

   modport slave (
      input  test_idx,
      input  test_req,
      output test_busy,
      output test_return
   );
endinterface

// File: rtl/synth_test_sequencer.sv
// Runs a req/busy/return test method for every index and collects verdicts.
// Optional TEST_SEQ_STOP_ON_FAIL_EN: stop the run at the first failure.
module synth_test_sequencer #(
   parameter int NUM_TESTS = 16,
   parameter int TIMEOUT   = 100000,
   parameter int TO_W      = 17
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   synth_test_sequencer_if.master m,
   output logic                  seq_busy,
   output logic                  seq_done,
   output logic                  all_pass,
   output logic [15:0]           fail_count,
   output logic [15:0]           first_fail,
   output logic                  timeout_seen
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_NEXT,
      S_DONE
   } state_t;

   localparam logic [15:0]   IDX_LAST = 16'(NUM_TESTS - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t          state;
   state_t          state_nxt;
   logic [15:0]     idx;
   logic [TO_W-1:0] cnt;
   logic            ok_q;
   logic            to_hit;
   logic            last;
   logic            stop;
   logic            accept;
   logic            complete;

   assign to_hit   = (cnt == TO_LAST);
   assign last     = (idx == IDX_LAST);
   assign accept   = start &&
                     (state == S_IDLE || state == S_DONE);
   // Completion beats a coincident timeout once busy has been seen.
   assign complete = (state == S_WAIT) && !m.test_busy;

`ifdef TEST_SEQ_STOP_ON_FAIL_EN
   assign stop = last || !ok_q;
`else
   assign stop = last;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE,
         S_DONE: begin
            if (start) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            if (to_hit)
               state_nxt = S_NEXT;
            else if (m.test_busy)
               state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (!m.test_busy || to_hit)
               state_nxt = S_NEXT;
         end
         S_NEXT: begin
            state_nxt = stop ? S_DONE : S_ISSUE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      m.test_req = 1'b0;
      seq_busy   = 1'b0;
      seq_done   = 1'b0;
      unique case (1'b1)
         (state == S_ISSUE): begin
            m.test_req = 1'b1;
            seq_busy   = 1'b1;
         end
         (state == S_WAIT),
         (state == S_NEXT): seq_busy = 1'b1;
         (state == S_DONE): seq_done = 1'b1;
         default: ;
      endcase
   end

   assign m.test_idx = {16'd0, idx};

   always_ff @(posedge clk) begin
      if (reset) begin
         idx          <= '0;
         cnt          <= '0;
         ok_q         <= 1'b0;
         all_pass     <= 1'b0;
         fail_count   <= '0;
         first_fail   <= 16'hFFFF;
         timeout_seen <= 1'b0;
      end else if (accept) begin
         idx          <= '0;
         cnt          <= '0;
         ok_q         <= 1'b0;
         all_pass     <= 1'b0;
         fail_count   <= '0;
         first_fail   <= 16'hFFFF;
         timeout_seen <= 1'b0;
      end else begin
         if (state == S_ISSUE || state == S_WAIT) begin
            cnt <= cnt + TO_W'(1);
            if (state_nxt == S_NEXT) begin
               ok_q <= complete && m.test_return;
               if (!complete) timeout_seen <= 1'b1;
            end
         end
         if (state == S_NEXT) begin
            if (!ok_q) begin
               if (fail_count != 16'hFFFF)
                  fail_count <= fail_count + 16'd1;
               if (first_fail == 16'hFFFF)
                  first_fail <= idx;
            end
            if (stop) begin
               all_pass <= (fail_count == 16'd0) && ok_q;
            end else begin
               idx <= idx + 16'd1;
               cnt <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_synth_test_sequencer.sv
// Randomized bench for synth_test_sequencer with a behavioural
// DUT-method model and a per-run expected-verdict model.
module tb_synth_test_sequencer;

   localparam int N  = 4;
   localparam int TO = 50;

   logic        clk = 0;
   logic        reset;
   logic        start;
   logic        seq_busy;
   logic        seq_done;
   logic        all_pass;
   logic [15:0] fail_count;
   logic [15:0] first_fail;
   logic        timeout_seen;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] fail_mask   = '0;
   bit          hang_en     = 0;
   logic [15:0] hang_idx    = '0;
   bit          never_raise = 0;
   logic [15:0] issued[$];
   logic        req_q = 0;

   synth_test_sequencer_if ifc ();

   synth_test_sequencer #(
      .NUM_TESTS(N),
      .TIMEOUT  (TO),
      .TO_W     (17)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .m           (ifc.master),
      .seq_busy    (seq_busy),
      .seq_done    (seq_done),
      .all_pass    (all_pass),
      .fail_count  (fail_count),
      .first_fail  (first_fail),
      .timeout_seen(timeout_seen)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   // Method model: random start delay, random busy length, verdict
   // driven opposite while busy so only the busy-fall value is right.
   initial begin : method_model
      logic [15:0] cur;
      int k;
      ifc.test_busy   = 0;
      ifc.test_return = 0;
      forever begin
         @(negedge clk);
         if (ifc.test_req === 1'b1 && !never_raise && !reset) begin
            cur = ifc.test_idx[15:0];
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ifc.test_busy   = 1;
            ifc.test_return = fail_mask[cur];
            if (hang_en && cur == hang_idx) begin
               k = 0;
               while (ifc.test_idx[15:0] == cur && !seq_done &&
                      !reset && k < 1000) begin
                  @(negedge clk);
                  k++;
               end
            end else begin
               repeat ($urandom_range(1, 12)) @(negedge clk);
            end
            ifc.test_busy   = 0;
            ifc.test_return = !fail_mask[cur];
         end
      end
   end

   initial begin : req_log
      forever begin
         @(negedge clk);
         if (ifc.test_req === 1'b1 && !req_q)
            issued.push_back(ifc.test_idx[15:0]);
         req_q = ifc.test_req;
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_idx"}, ifc.test_idx, 32'd0);
      check({tag, "_req"}, {31'd0, ifc.test_req}, 32'd0);
      check({tag, "_busy"}, {31'd0, seq_busy}, 32'd0);
      check({tag, "_done"}, {31'd0, seq_done}, 32'd0);
      check({tag, "_pass"}, {31'd0, all_pass}, 32'd0);
      check({tag, "_fcnt"}, {16'd0, fail_count}, 32'd0);
      check({tag, "_ffst"}, {16'd0, first_fail}, 32'hFFFF);
      check({tag, "_to"}, {31'd0, timeout_seen}, 32'd0);
   endtask

   task automatic run_case(input string tag,
                           input logic [15:0] mask,
                           input int hang,
                           input bit nr,
                           input bit poke);
      logic [15:0] exp_list[$];
      int          exp_cnt;
      logic [15:0] exp_first;
      bit          exp_to;
      bit          bad;
      bit          tmo;
      int          k;

      fail_mask   = mask;
      hang_en     = (hang >= 0);
      hang_idx    = 16'(hang);
      never_raise = nr;

      exp_cnt   = 0;
      exp_first = 16'hFFFF;
      exp_to    = 0;
      for (int i = 0; i < N; i++) begin
         exp_list.push_back(16'(i));
         tmo = nr || (hang >= 0 && hang == i);
         bad = tmo || mask[i];
         if (bad) begin
            exp_cnt++;
            if (exp_first == 16'hFFFF) exp_first = 16'(i);
            if (tmo) exp_to = 1;
`ifdef TEST_SEQ_STOP_ON_FAIL_EN
            break;
`endif
         end
      end

      issued.delete();
      pulse_start();
      check({tag, "_s_busy"}, {31'd0, seq_busy}, 32'd1);
      check({tag, "_s_done"}, {31'd0, seq_done}, 32'd0);
      check({tag, "_s_fcnt"}, {16'd0, fail_count}, 32'd0);
      check({tag, "_s_ffst"}, {16'd0, first_fail}, 32'hFFFF);
      check({tag, "_s_to"}, {31'd0, timeout_seen}, 32'd0);
      check({tag, "_s_pass"}, {31'd0, all_pass}, 32'd0);

      if (poke) begin
         repeat (3) @(negedge clk);
         pulse_start();
      end

      k = 0;
      while (!seq_done && k < 20000) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_done"}, {31'd0, seq_done}, 32'd1);
      check({tag, "_busy"}, {31'd0, seq_busy}, 32'd0);
      check({tag, "_req"}, {31'd0, ifc.test_req}, 32'd0);
      check({tag, "_pass"}, {31'd0, all_pass},
            {31'd0, exp_cnt == 0});
      check({tag, "_fcnt"}, {16'd0, fail_count}, 32'(exp_cnt));
      check({tag, "_ffst"}, {16'd0, first_fail},
            {16'd0, exp_first});
      check({tag, "_to"}, {31'd0, timeout_seen}, {31'd0, exp_to});
      check({tag, "_nissued"}, 32'(issued.size()),
            32'(exp_list.size()));
      for (int i = 0; i < exp_list.size() && i < issued.size(); i++)
         check({tag, "_order"}, {16'd0, issued[i]},
               {16'd0, exp_list[i]});

      repeat (3) @(negedge clk);
      check({tag, "_hold"}, {31'd0, seq_done}, 32'd1);
      hang_en     = 0;
      never_raise = 0;
   endtask

   initial begin : stim
      int k;
      reset = 1;
      start = 1;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      start = 0;
      reset = 0;
      repeat (2) @(negedge clk);
      check("idle_busy", {31'd0, seq_busy}, 32'd0);

      run_case("pass", 16'h0, -1, 0, 0);
      run_case("fail13", 16'hA, -1, 0, 0);
      run_case("fail13_rerun", 16'hA, -1, 0, 0);
      run_case("hang2", 16'h0, 2, 0, 0);
      run_case("noraise", 16'h0, -1, 1, 0);
      run_case("poke", 16'h2, -1, 0, 1);

      hang_en  = 1;
      hang_idx = 16'd2;
      pulse_start();
      k = 0;
      while (!(ifc.test_busy && !ifc.test_req &&
               ifc.test_idx == 32'd2) && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("mid_wait2", {31'd0, ifc.test_busy}, 32'd1);
      reset = 1;
      @(negedge clk);
      check_reset_vals("midrst");
      reset   = 0;
      hang_en = 0;
      repeat (20) @(negedge clk);
      run_case("after_rst", 16'h0, -1, 0, 0);

      for (int r = 0; r < 6; r++) begin
         run_case("rand", 16'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0) ?
                     int'($urandom_range(0, N - 1)) : -1,
                  0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
